dcache_ctrl_fsm: RTL and testbench
==================================

Name: dcache_ctrl_fsm

Overview:
- Write-back, write-allocate miss controller for the direct-mapped L1 data cache: 4096 lines × 128-bit blocks, byte-offset partial stores.
- Sits between the memory stage, the data/tag arrays and the memory bus.
- Decides hit/miss from tag-array status and sequences victim write-back and block refill over a valid/ready memory handshake.
- Drives the data-array enables and stalls the pipeline until the access can complete.

Parameters:
- MEM_WAIT_MAX, 255, cycles a memory request may stay unanswered before bus_err pulses (8-bit watchdog).

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- cpu_rden  in  1  load request, held stable while stall=1
- cpu_wren  in  1  store request, held stable while stall=1
- tag_hit  in  1  tag array: line valid and tag matches
- tag_dirty  in  1  tag array: indexed line dirty
- mem_ready  in  1  memory completes current request this cycle
- stall  out  1  freeze pipeline
- data_wren  out  1  data-array write enable
- data_rden  out  1  data-array read enable (victim read)
- data_mem_in  out  1  1 = full-block refill write, 0 = partial store
- tag_wren  out  1  write tag/valid/dirty for indexed line
- tag_dirty_set  out  1  dirty value written with tag_wren
- mem_rden  out  1  block read request to memory
- mem_wren  out  1  block write request to memory
- victim_addr_sel  out  1  1 = memory address from stored victim tag, 0 = CPU address
- bus_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- States: IDLE, WRITE_BACK, ALLOCATE. Outputs are Moore/Mealy combinational from state plus inputs; no output registers. Async rst forces IDLE and clears the watchdog, so every output reads 0 during reset.
- Request: req = cpu_rden | cpu_wren. With both high, the access is treated as a store.
- IDLE:
  - req=0: all outputs 0.
  - Read hit: stall=0. Data is returned combinationally by the array the same cycle (zero-latency hit).
  - Write hit: stall=0; data_wren=1, data_mem_in=0, tag_wren=1, tag_dirty_set=1. The array commits on the following negedge.
  - Miss, clean (tag_hit=0, tag_dirty=0): stall=1; next state ALLOCATE.
  - Miss, dirty (tag_hit=0, tag_dirty=1): stall=1; next state WRITE_BACK.
- WRITE_BACK:
  - Outputs: stall=1, mem_wren=1, data_rden=1, victim_addr_sel=1, data_wren=0.
  - On mem_ready: next state ALLOCATE.
- ALLOCATE:
  - Outputs: stall=1, mem_rden=1, victim_addr_sel=0.
  - On mem_ready: data_wren=1, data_mem_in=1, tag_wren=1, tag_dirty_set=0; next state IDLE.
  - The following IDLE cycle re-evaluates and now hits; a store then merges its bytes via the write-hit path.
- Latency:
  - Clean miss = 1 + refill wait + 1 cycles to completion.
  - Dirty miss additionally adds the write-back wait.
- Invariants:
  - data_wren and data_rden never both 1, because the array ignores writes while rden=1.
  - mem_rden and mem_wren are mutually exclusive.
- mem_ready boundary cases:
  - Ignored in IDLE.
  - Asserted in the first cycle of WRITE_BACK or ALLOCATE is legal and gives a single-cycle memory transfer.
- Watchdog: counts cycles spent in WRITE_BACK/ALLOCATE without mem_ready and resets on every state change.
  - When it reaches MEM_WAIT_MAX: bus_err pulses 1 cycle, counter saturates, FSM keeps waiting.
- Reset mid-refill: outstanding request is dropped immediately and no array write occurs. Memory must tolerate request withdrawal.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hits[31:0] and perf_misses[31:0], both reset to 0.
  - perf_hits increments on every IDLE cycle with req=1 and tag_hit=1.
  - perf_misses increments on every IDLE→WRITE_BACK/ALLOCATE transition.
  - Both counters wrap at 2^32.
  - A post-refill re-hit counts as a hit.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_cache_pkg:
  - cache_state_t enum {IDLE, WRITE_BACK, ALLOCATE}
  - storesrc encodings SB=2'b00, SH=2'b01, SW=2'b10, SD=2'b11
  - constants INDEX=12, DWIDTH=128, CACHE_DEPTH=4096, BYTE_OFFSET=4
- Sub-module: dcache_perf_cnt, the two saturation-free counters, instantiated only under DCACHE_PERF_CNT_EN.

Test Plan:
- Load hit: cpu_rden=1, tag_hit=1 → stall=0 same cycle, no mem_* asserted, state stays IDLE.
- Store hit: cpu_wren=1, tag_hit=1 → data_wren=1, data_mem_in=0, tag_wren=1, tag_dirty_set=1, stall=0 for exactly 1 cycle.
- Clean load miss, mem_ready after 3 cycles:
  - Response: IDLE→ALLOCATE; mem_rden high for 3 cycles.
  - On the ready cycle: data_wren=1, data_mem_in=1, tag_dirty_set=0.
  - The next cycle (tag_hit=1) drops stall.
- Dirty store miss, mem_ready after 2 cycles then 4 cycles:
  - WRITE_BACK with mem_wren=1, data_rden=1, victim_addr_sel=1 for 2 cycles.
  - ALLOCATE for 4 cycles.
  - Final IDLE cycle performs the partial store with tag_dirty_set=1.
- Watchdog: MEM_WAIT_MAX=4, mem_ready withheld → bus_err pulses once after 4 ALLOCATE cycles; a later mem_ready still completes the refill.
- Reset mid-ALLOCATE: assert rst asynchronously → mem_rden, stall, data_wren fall immediately. After release, state is IDLE with no array write.

Source files
------------

// File: rtl/riscv_cache_pkg.sv
// Shared types and geometry for the L1 data-cache controller.
package riscv_cache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } cache_state_t;

    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10,
        SD = 2'b11
    } storesrc_t;

    localparam int INDEX       = 12;
    localparam int DWIDTH      = 128;
    localparam int CACHE_DEPTH = 4096;
    localparam int BYTE_OFFSET = 4;

    // States in which a memory transfer is outstanding.
    function automatic logic waits_on_mem(input logic [1:0] st);
        return (st == WRITE_BACK) || (st == ALLOCATE);
    endfunction

endpackage

// File: rtl/dcache_ctrl_fsm_if.sv
// Pipeline, tag-array, data-array and memory-bus signals of the miss controller.
interface dcache_ctrl_fsm_if;
    logic cpu_rden;
    logic cpu_wren;
    logic tag_hit;
    logic tag_dirty;
    logic mem_ready;
    logic stall;
    logic data_wren;
    logic data_rden;
    logic data_mem_in;
    logic tag_wren;
    logic tag_dirty_set;
    logic mem_rden;
    logic mem_wren;
    logic victim_addr_sel;
    logic bus_err;

    modport master (
        input  cpu_rden, cpu_wren, tag_hit, tag_dirty, mem_ready,
        output stall, data_wren, data_rden, data_mem_in, tag_wren,
               tag_dirty_set, mem_rden, mem_wren, victim_addr_sel, bus_err
    );

    modport slave (
        output cpu_rden, cpu_wren, tag_hit, tag_dirty, mem_ready,
        input  stall, data_wren, data_rden, data_mem_in, tag_wren,
               tag_dirty_set, mem_rden, mem_wren, victim_addr_sel, bus_err
    );
endinterface

// File: rtl/dcache_perf_cnt.sv
// Free-running hit/miss event counters; both wrap at 2^32.
module dcache_perf_cnt
    import riscv_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_i,
    input  logic        miss_i,
    output logic [31:0] hits_o,
    output logic [31:0] misses_o
);
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;

    // Next counter values.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (hit_i) begin
            hits_d = hits_q + 32'd1;
        end else begin
            hits_d = hits_q;
        end
        if (miss_i) begin
            misses_d = misses_q + 32'd1;
        end else begin
            misses_d = misses_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= 32'd0;
            misses_q <= 32'd0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign hits_o   = hits_q;
    assign misses_o = misses_q;
endmodule

// File: rtl/dcache_ctrl_fsm.sv
// Write-back / write-allocate miss controller for the direct-mapped L1 D-cache.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl_fsm
    import riscv_cache_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    dcache_ctrl_fsm_if.master  bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_hits,
    output logic [31:0]        perf_misses
`endif
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WB   = WRITE_BACK;
    localparam logic [1:0] S_AL   = ALLOCATE;
    localparam logic [7:0] WD_MAX = 8'(MEM_WAIT_MAX);
    localparam logic [7:0] WD_PRE = 8'(MEM_WAIT_MAX) - 8'd1;

    logic [1:0] state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic       req_s;
    logic       stall_s, data_wren_s, data_rden_s, data_mem_in_s;
    logic       tag_wren_s, tag_dirty_set_s, mem_rden_s, mem_wren_s;
    logic       victim_sel_s, bus_err_s;

    assign req_s = bus.cpu_rden | bus.cpu_wren;

    // Next-state, watchdog and array/bus control decode.
    always_comb begin
        state_d         = state_q;
        wd_d            = 8'd0;
        stall_s         = 1'b0;
        data_wren_s     = 1'b0;
        data_rden_s     = 1'b0;
        data_mem_in_s   = 1'b0;
        tag_wren_s      = 1'b0;
        tag_dirty_set_s = 1'b0;
        mem_rden_s      = 1'b0;
        mem_wren_s      = 1'b0;
        victim_sel_s    = 1'b0;
        bus_err_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s && bus.tag_hit) begin
                    // A store wins over a simultaneous load and merges its bytes here.
                    if (bus.cpu_wren) begin
                        data_wren_s     = 1'b1;
                        tag_wren_s      = 1'b1;
                        tag_dirty_set_s = 1'b1;
                    end else begin
                        data_wren_s     = 1'b0;
                    end
                end else if (req_s) begin
                    stall_s = 1'b1;
                    state_d = bus.tag_dirty ? S_WB : S_AL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                stall_s      = 1'b1;
                mem_wren_s   = 1'b1;
                data_rden_s  = 1'b1;
                victim_sel_s = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_AL;
                end else begin
                    wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + 8'd1;
                    bus_err_s = (wd_q == WD_PRE);
                end
            end
            S_AL: begin
                stall_s    = 1'b1;
                mem_rden_s = 1'b1;
                if (bus.mem_ready) begin
                    data_wren_s   = 1'b1;
                    data_mem_in_s = 1'b1;
                    tag_wren_s    = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + 8'd1;
                    bus_err_s = (wd_q == WD_PRE);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Reset masks the combinational outputs so a withdrawn request drops at once.
    assign bus.stall           = stall_s         & ~rst;
    assign bus.data_wren       = data_wren_s     & ~rst;
    assign bus.data_rden       = data_rden_s     & ~rst;
    assign bus.data_mem_in     = data_mem_in_s   & ~rst;
    assign bus.tag_wren        = tag_wren_s      & ~rst;
    assign bus.tag_dirty_set   = tag_dirty_set_s & ~rst;
    assign bus.mem_rden        = mem_rden_s      & ~rst;
    assign bus.mem_wren        = mem_wren_s      & ~rst;
    assign bus.victim_addr_sel = victim_sel_s    & ~rst;
    assign bus.bus_err         = bus_err_s & waits_on_mem(state_q) & ~rst;

`ifdef DCACHE_PERF_CNT_EN
    logic hit_evt_s, miss_evt_s;
    assign hit_evt_s  = (state_q == S_IDLE) & req_s & bus.tag_hit;
    assign miss_evt_s = (state_q == S_IDLE) & req_s & ~bus.tag_hit;

    dcache_perf_cnt u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .hit_i    (hit_evt_s),
        .miss_i   (miss_evt_s),
        .hits_o   (perf_hits),
        .misses_o (perf_misses)
    );
`endif
endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Scoreboard bench for dcache_ctrl_fsm against a transaction-level reference model.
module tb_dcache_ctrl_fsm;
    localparam int WAIT_MAX = 4;
    localparam int PH_IDLE = 0, PH_WB = 1, PH_AL = 2;

    logic clk;
    logic rst;
    dcache_ctrl_fsm_if bus ();
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    dcache_ctrl_fsm #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bit order: stall, data_wren, data_rden, data_mem_in, tag_wren,
    // tag_dirty_set, mem_rden, mem_wren, victim_addr_sel, bus_err.
    logic [9:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    int m_phase = PH_IDLE;
    int m_wait = 0;
    int m_hits = 0;
    int m_misses = 0;
    bit m_refilled = 1'b0;
    bit last_stall = 1'b0;
    logic cur_rd = 1'b0, cur_wr = 1'b0;

    function automatic logic [9:0] dut_out();
        return {bus.stall, bus.data_wren, bus.data_rden, bus.data_mem_in, bus.tag_wren,
                bus.tag_dirty_set, bus.mem_rden, bus.mem_wren, bus.victim_addr_sel, bus.bus_err};
    endfunction

    task automatic model_step(input logic rd, input logic wr, input logic hit,
                              input logic dirty, input logic ready, output logic [9:0] e);
        e = 10'd0;
        m_refilled = 1'b0;
        if (m_phase == PH_IDLE) begin
            if ((rd | wr) && hit) begin
                m_hits++;
                if (wr) begin
                    e[8] = 1'b1; e[5] = 1'b1; e[4] = 1'b1;
                end
            end else if (rd | wr) begin
                e[9] = 1'b1;
                m_misses++;
                m_phase = dirty ? PH_WB : PH_AL;
                m_wait = 0;
            end
        end else begin
            e[9] = 1'b1;
            if (m_phase == PH_WB) begin
                e[2] = 1'b1; e[7] = 1'b1; e[1] = 1'b1;
            end else begin
                e[3] = 1'b1;
            end
            if (ready) begin
                if (m_phase == PH_AL) begin
                    e[8] = 1'b1; e[6] = 1'b1; e[5] = 1'b1;
                    m_refilled = 1'b1;
                end
                m_phase = (m_phase == PH_WB) ? PH_AL : PH_IDLE;
                m_wait = 0;
            end else begin
                if (m_wait + 1 == WAIT_MAX) e[0] = 1'b1;
                if (m_wait < WAIT_MAX) m_wait++;
            end
        end
    endtask

    task automatic cycle(input logic rd, input logic wr, input logic hit,
                         input logic dirty, input logic ready);
        logic [9:0] e;
        @(posedge clk);
        #1;
        bus.cpu_rden  = rd;
        bus.cpu_wren  = wr;
        bus.tag_hit   = hit;
        bus.tag_dirty = dirty;
        bus.mem_ready = ready;
        model_step(rd, wr, hit, dirty, ready, e);
        exp_q.push_back(e);
        last_stall = e[9];
    endtask

    task automatic miss_seq(input logic rd, input logic wr, input logic dirty,
                            input int wb_wait, input int al_wait);
        cycle(rd, wr, 1'b0, dirty, 1'b0);
        if (dirty) begin
            for (int i = 0; i < wb_wait; i++) cycle(rd, wr, 1'b0, dirty, i == wb_wait - 1);
        end
        for (int i = 0; i < al_wait; i++) cycle(rd, wr, 1'b0, 1'b0, i == al_wait - 1);
        cycle(rd, wr, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_now(input string name, input logic [9:0] got, input logic [9:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, got, req);
        end
    endtask

    // Monitor: compare every cycle's outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            logic [9:0] g;
            e = exp_q.pop_front();
            g = dut_out();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got %b, expected %b", $time, g, e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.cpu_rden = 1'b1; bus.cpu_wren = 1'b1; bus.tag_hit = 1'b1;
        bus.tag_dirty = 1'b1; bus.mem_ready = 1'b1;
        #3;
        check_now("reset_outputs", dut_out(), 10'd0);
        bus.cpu_rden = 1'b0; bus.cpu_wren = 1'b0; bus.tag_hit = 1'b0;
        bus.tag_dirty = 1'b0; bus.mem_ready = 1'b0;
        #9;
        rst = 1'b0;

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);           // idle, ready ignored
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);           // load hit
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);           // store hit
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);           // both -> store
        miss_seq(1'b1, 1'b0, 1'b0, 0, 3);              // clean load miss
        miss_seq(1'b0, 1'b1, 1'b1, 2, 4);              // dirty store miss
        miss_seq(1'b1, 1'b0, 1'b1, 1, 1);              // single-cycle transfers
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);           // miss entry with ready high
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        miss_seq(1'b1, 1'b0, 1'b0, 0, 7);              // watchdog in ALLOCATE
        miss_seq(1'b0, 1'b1, 1'b1, 9, 2);              // watchdog in WRITE_BACK

        // Reset withdrawn mid-refill.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_now("alloc_before_rst", dut_out(), 10'b1000001000);
        #1;
        rst = 1'b1;
        #1;
        check_now("alloc_rst_drop", dut_out(), 10'd0);
        bus.cpu_rden = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        m_phase = PH_IDLE; m_wait = 0; m_hits = 0; m_misses = 0; last_stall = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic obeying the hold-while-stalled rule.
        for (int n = 0; n < 600; n++) begin
            logic h;
            if (!last_stall) begin
                case ($urandom_range(0, 3))
                    0: begin cur_rd = 1'b0; cur_wr = 1'b0; end
                    1: begin cur_rd = 1'b1; cur_wr = 1'b0; end
                    2: begin cur_rd = 1'b0; cur_wr = 1'b1; end
                    default: begin cur_rd = 1'b1; cur_wr = 1'b1; end
                endcase
            end
            h = m_refilled ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(cur_rd, cur_wr, h, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        end

        @(posedge clk);
        #1;
        bus.cpu_rden = 1'b0; bus.cpu_wren = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
`ifdef DCACHE_PERF_CNT_EN
        vectors++;
        if (perf_hits !== 32'(m_hits)) begin
            miscompares++;
            $display("FAIL perf_hits: got %0d, expected %0d", perf_hits, m_hits);
        end
        vectors++;
        if (perf_misses !== 32'(m_misses)) begin
            miscompares++;
            $display("FAIL perf_misses: got %0d, expected %0d", perf_misses, m_misses);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
